// File: rtl/celchain_delay_meas.sv
// Delay sequencer for C-element inverter chains: toggles the selected chain input and
// counts clk cycles until its synchronized output follows, accumulated over several trials.
module celchain_delay_meas #(
    parameter int NUM_CHAINS  = 4,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SETTLE_CYC  = 8,
    parameter int TRIALS_W    = 3,
    parameter int ACC_W       = CNT_W + TRIALS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_W-1:0]      chain_sel,
    input  logic [TRIALS_W-1:0]   num_trials,
    output logic [NUM_CHAINS-1:0] chain_in,
    input  logic [NUM_CHAINS-1:0] chain_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_sel,
    output logic [ACC_W-1:0]      result
);

    localparam int                STL_W        = $clog2(SETTLE_CYC);
    localparam logic [STL_W-1:0]  SETTLE_LAST  = STL_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_L    = CNT_W'(TIMEOUT_CYC);
    localparam logic [SEL_W:0]    NUM_CHAINS_L = (SEL_W + 1)'(NUM_CHAINS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LAUNCH,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_CHAINS-1:0] sync_p0, sync_p1;
    logic [SEL_W-1:0]      sel_lat;
    logic [TRIALS_W-1:0]   trials_lat;
    logic                  baseline;
    logic [STL_W-1:0]      settle_cnt;
    logic [CNT_W-1:0]      cnt;
    logic [TRIALS_W-1:0]   trial;

    logic [NUM_CHAINS-1:0] sel_onehot;
    logic                  sel_bit;
    logic                  detect;
    logic                  settle_last;
    logic                  sel_bad;
    logic                  in_meas;
    logic                  abort_act;

    // One-hot select avoids a wide index into the chain vector; an out-of-range sel yields zero.
    assign sel_onehot  = NUM_CHAINS'(1) << sel_lat;
    assign sel_bit     = |(sync_p1 & sel_onehot);
    assign detect      = (sel_bit != baseline);
    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign sel_bad     = ({1'b0, chain_sel} >= NUM_CHAINS_L);
    assign in_meas     = (state == S_SETTLE) || (state == S_LAUNCH) || (state == S_MEASURE);
    assign abort_act   = abort && in_meas;

    // Stage p0 -> p1: two-flop synchronizer on the asynchronous chain outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= chain_out;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (start) state_nxt = sel_bad ? S_DONE : S_SETTLE;
                S_SETTLE:  if (settle_last) state_nxt = S_LAUNCH;
                S_LAUNCH:  state_nxt = S_MEASURE;
                S_MEASURE: begin
                    if (detect)                 state_nxt = (trial == trials_lat) ? S_DONE : S_SETTLE;
                    else if (cnt == TIMEOUT_L)  state_nxt = S_DONE;
                end
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = in_meas;
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_in    <= '0;
            result      <= '0;
            err_timeout <= 1'b0;
            err_sel     <= 1'b0;
            settle_cnt  <= '0;
            cnt         <= '0;
            trial       <= '0;
        end else if (!abort_act) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        result      <= '0;
                        err_timeout <= 1'b0;
                        err_sel     <= sel_bad;
                        settle_cnt  <= '0;
                        trial       <= '0;
                    end
                end
                S_SETTLE: settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
                S_LAUNCH: begin
                    chain_in <= chain_in ^ sel_onehot;
                    cnt      <= '0;
                end
                S_MEASURE: begin
                    // Detect has priority over the timeout in the same cycle.
                    if (detect) begin
                        result     <= result + ACC_W'(cnt);
                        trial      <= trial + 1'b1;
                        settle_cnt <= '0;
                    end else if (cnt == TIMEOUT_L) begin
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  ;
                default: ;
            endcase
        end
    end

    // Request parameters and baseline carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            sel_lat    <= chain_sel;
            trials_lat <= num_trials;
        end
        if (state == S_SETTLE && settle_last) begin
            baseline <= sel_bit;
        end
    end

endmodule

// File: tb/tb_celchain_delay_meas.sv
// Bench for celchain_delay_meas: behavioural chain models, randomized requests and a
// done-triggered scoreboard that compares each completion against predicted results.
module tb_celchain_delay_meas;

    localparam int NC = 4;
    localparam int SW = 3;
    localparam int CW = 10;
    localparam int TO = 1000;
    localparam int SC = 8;
    localparam int TW = 3;
    localparam int AW = CW + TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [SW-1:0] chain_sel;
    logic [TW-1:0] num_trials;
    logic [NC-1:0] chain_in;
    logic [NC-1:0] chain_out;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_sel;
    logic [AW-1:0] result;

    celchain_delay_meas #(
        .NUM_CHAINS(NC), .SEL_W(SW), .CNT_W(CW), .TIMEOUT_CYC(TO),
        .SETTLE_CYC(SC), .TRIALS_W(TW), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .chain_sel(chain_sel), .num_trials(num_trials),
        .chain_in(chain_in), .chain_out(chain_out),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_sel(err_sel),
        .result(result)
    );

    always #5 clk = ~clk;

    // Chain model: each output follows its input after dly[i] clock edges, or sticks at 0.
    int            dly[NC];
    logic [NC-1:0] stuck;
    logic [NC-1:0] hist[16];

    always @(posedge clk) begin
        for (int k = 15; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= chain_in;
    end

    always_comb begin
        chain_out = '0;
        for (int i = 0; i < NC; i++) begin
            if (stuck[i])        chain_out[i] = 1'b0;
            else if (dly[i] == 0) chain_out[i] = chain_in[i];
            else                 chain_out[i] = hist[dly[i]-1][i];
        end
    end

    typedef struct {
        logic [AW-1:0] res;
        logic          eto;
        logic          esel;
        logic [NC-1:0] ci;
        int            lat;
        int            t0;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [NC-1:0] model_ci;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic          prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: per-trial count is chain delay plus two synchronizer cycles.
    task automatic predict(input int sel, input int ntr, output exp_t e);
        int t;
        int c;
        t      = ntr + 1;
        e.res  = '0;
        e.eto  = 1'b0;
        e.esel = 1'b0;
        e.t0   = 0;
        if (sel >= NC) begin
            e.esel = 1'b1;
            e.lat  = 1;
        end else if (stuck[sel]) begin
            e.eto         = 1'b1;
            e.lat         = SC + 1 + (TO + 1) + 1;
            model_ci[sel] = ~model_ci[sel];
        end else begin
            c     = dly[sel] + 2;
            e.res = AW'(t * c);
            e.lat = t * (SC + 1 + c + 1) + 1;
            if (t % 2 == 1) model_ci[sel] = ~model_ci[sel];
        end
        e.ci = model_ci;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_expected", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("err_timeout", 32'(err_timeout), 32'(mon_e.eto));
                chk("err_sel", 32'(err_sel), 32'(mon_e.esel));
                chk("chain_in", 32'(chain_in), 32'(mon_e.ci));
                chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
                chk("busy_at_done", 32'(busy), 0);
                chk("busy_before_done", 32'(prev_busy), mon_e.esel ? 0 : 1);
            end
        end
        prev_busy <= busy;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && done == 1'b0 && sb_q.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual=busy%0d_q%0d required=idle", busy, sb_q.size());
        end
    endtask

    task automatic run_meas(input int sel, input int ntr, input bit wig);
        exp_t e;
        wait_idle();
        predict(sel, ntr, e);
        e.t0 = cyc;
        sb_q.push_back(e);
        chain_sel  = SW'(sel);
        num_trials = TW'(ntr);
        start      = 1'b1;
        abort      = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        abort = 1'b0;
        if (wig && sel < NC) begin
            repeat (5) begin
                start      = 1'($urandom_range(0, 1));
                chain_sel  = SW'($urandom);
                num_trials = TW'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
        chk({tag, "_err_sel"}, 32'(err_sel), 0);
        chk({tag, "_chain_in"}, 32'(chain_in), 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        chain_sel  = '0;
        num_trials = '0;
        stuck      = '0;
        model_ci   = '0;
        for (int i = 0; i < NC; i++) dly[i] = 0;
        for (int k = 0; k < 16; k++) hist[k] = '0;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Zero-delay chain, single trial
        run_meas(1, 0, 1'b0);

        // Five-cycle chain, four trials
        wait_idle();
        dly[0] = 5;
        run_meas(0, 3, 1'b0);

        // Stuck chain times out
        wait_idle();
        stuck[2] = 1'b1;
        run_meas(2, 0, 1'b0);

        // Out-of-range select
        wait_idle();
        stuck = '0;
        run_meas(5, 2, 1'b0);

        // Abort in the middle of trial 2
        wait_idle();
        dly[1]     = 0;
        chain_sel  = 1;
        num_trials = 3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", 32'(result), 2);
        chk("abort_chain_in", 32'(chain_in), 32'(model_ci));
        repeat (3) @(negedge clk);
        chk("abort_result_hold", 32'(result), 2);
        run_meas(1, 0, 1'b0);

        // Asynchronous reset during the second settle phase
        wait_idle();
        dly[3]     = 0;
        chain_sel  = 3;
        num_trials = 1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_result", 32'(result), 2);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_ci = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized requests with start/sel/trials wiggled while busy
        for (int it = 0; it < 30; it++) begin
            int sel;
            wait_idle();
            for (int c = 0; c < NC; c++) dly[c] = $urandom_range(0, 6);
            stuck = '0;
            if ($urandom_range(0, 11) == 0) stuck[$urandom_range(0, NC-1)] = 1'b1;
            sel = ($urandom_range(0, 7) < 6) ? $urandom_range(0, NC-1) : $urandom_range(NC, 7);
            run_meas(sel, $urandom_range(0, 7), 1'b1);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
